multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel timer/counter peripheral on the CPU bridge, successor to the single-channel timer device. Up to four independent down-counters, each with one-shot or periodic auto-reload mode, a sticky pending flag cleared by write-1-to-clear, and a per-channel interrupt mask. Sits behind the bridge with a word-addressed register bus and drives one combined interrupt line plus a per-channel interrupt vector to the CP0 hardware-interrupt inputs.

## Interface
- NCH, 2, number of channels, legal range 1..4
- CW, 32, counter/preset width in bits, legal range 1..32
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all channel state
- Addr  in  30 (Addr[31:2])  word address; Addr[5:4] selects channel, Addr[3:2] selects register, upper bits ignored (bridge decodes)
- WE  in  1  write strobe for the addressed register
- Din  in  32  write data
- Dout  out  32  combinational read data of addressed register
- IRQ  out  1  OR of irq_vec
- irq_vec  out  NCH  per-channel interrupt = pending & IM

## Operation
- Per-channel registers, offset = Addr[3:2]:
  - 0 CTRL (rw): bit0 EN, bits[2:1] MODE (00 one-shot, 01 periodic, 1x reserved = one-shot), bit3 IM; writes keep Din[3:0], read upper bits 0
  - 1 PRESET (rw): CW bits, write truncates Din, read zero-extends
  - 2 COUNT (ro): CW bits zero-extended; writes ignored
  - 3 STATUS: bit0 PEND (write 1 clears, write 0 no effect), bit1 RUN (1 while state = CNT, read-only); other bits read 0
- Channel index >= NCH: reads return 0, writes ignored.
- Per-channel FSM IDLE / LOAD / CNT / INT:
  - IDLE: EN=1 -> LOAD
  - LOAD: COUNT <= PRESET -> CNT
  - CNT: EN=0 -> IDLE (COUNT holds); else COUNT>1 -> COUNT-1; else COUNT <= 0, PEND <= 1 -> INT
  - INT: one-shot -> clear EN, -> IDLE; periodic -> LOAD
- WE to a channel freezes that channel's FSM for that cycle (write applied, no FSM step); other channels advance normally.
- PEND is sticky; only W1C or reset clears it. Disabling EN does not clear PEND. IM gates irq_vec only, not PEND.
- PRESET written mid-count affects only the next LOAD.

## Timing
- Reset: all registers, COUNT, PEND, state = IDLE; Dout follows address (0 for every register), IRQ = 0, irq_vec = 0.
- EN written 1 in cycle T: IDLE in T+1, LOAD in T+2, CNT from T+3 with COUNT = PRESET.
- PRESET = P >= 1: P cycles in CNT (COUNT P..1), then COUNT = 0 and PEND = 1 visible the following cycle (INT).
- PRESET = 0: one CNT cycle, then INT.
- Periodic period = P + 2 cycles (CNT P, INT 1, LOAD 1); PEND edge every period.
- irq_vec/IRQ are registered-derived: high the same cycle PEND reads 1, low the cycle after a W1C.
- Terminal step and W1C on same channel/cycle: write wins, step deferred one cycle, PEND then sets.
- Reset mid-count: next cycle all state at reset values regardless of WE.

## Test plan
- Reset then read all 16 addresses (NCH=2) -> channels 0/1 all 0, channels 2/3 read 0, IRQ = 0.
- Ch0 PRESET=5, CTRL=0x9 (one-shot, IM) -> COUNT 5,4,3,2,1 then 0; IRQ rises 8 cycles after CTRL write; EN reads 0; STATUS=1; write STATUS=1 -> IRQ 0 next cycle.
- Ch1 PRESET=3, CTRL=0xB (periodic, IM) -> PEND sets every 5 cycles; COUNT reloads to 3; W1C each time keeps IRQ pulsing; writing CTRL=0x0 stops, RUN=0, COUNT holds.
- Ch0 counting with IM=0 -> PEND=1, irq_vec[0]=0, IRQ=0; then write CTRL IM=1 with EN=0 -> IRQ=1 next cycle.
- Both channels running, repeated writes to ch1 PRESET -> ch0 COUNT decrements every cycle unaffected; ch1 frozen on write cycles; new PRESET used only at ch1's next LOAD.
- CW=8: write PRESET=0x1FF -> reads 0xFF; PRESET=0 with EN -> PEND after single CNT cycle.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel down-counter timer: one-shot or periodic reload, sticky write-1-to-clear
// pending flags and per-channel interrupt masks behind a word-addressed register bus.
module multi_timer #(
   parameter int NCH = 2,
   parameter int CW  = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [31:2]    Addr,
   input  logic           WE,
   input  logic [31:0]    Din,
   output logic [31:0]    Dout,
   output logic           IRQ,
   output logic [NCH-1:0] irq_vec
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

   localparam logic [1:0] R_CTRL   = 2'd0;
   localparam logic [1:0] R_PRESET = 2'd1;
   localparam logic [1:0] R_COUNT  = 2'd2;
   localparam logic [1:0] R_STATUS = 2'd3;

   localparam int CTRL_EN = 0;
   localparam int CTRL_IM = 3;

   logic [1:0]    sel_ch;
   logic [1:0]    sel_reg;
   logic          unused_bits;

   state_t        state  [NCH];
   logic [3:0]    ctrl   [NCH];
   logic [CW-1:0] preset [NCH];
   logic [CW-1:0] count  [NCH];
   logic          pend   [NCH];

   assign sel_ch      = Addr[5:4];
   assign sel_reg     = Addr[3:2];
   assign unused_bits = ^{Addr[31:6], Din[31:4]};

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: every channel register is reset, not only the FSM, because any of them
         // may be read straight after reset and must return zero.
         for (int i = 0; i < NCH; i++) begin
            state[i]  <= S_IDLE;
            ctrl[i]   <= '0;
            preset[i] <= '0;
            count[i]  <= '0;
            pend[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (WE && sel_ch == 2'(i)) begin
               // A bus write to this channel takes priority and freezes its FSM this cycle.
               // NOTE: non-blocking assignments so every channel sees pre-edge values.
               case (sel_reg)
                  R_CTRL:   ctrl[i]   <= Din[3:0];
                  R_PRESET: preset[i] <= Din[CW-1:0];
                  R_STATUS: if (Din[0]) pend[i] <= 1'b0;
                  default:  ;
               endcase
            end else begin
               case (state[i])
                  S_IDLE: if (ctrl[i][CTRL_EN]) state[i] <= S_LOAD;
                  S_LOAD: begin
                     count[i] <= preset[i];
                     state[i] <= S_CNT;
                  end
                  S_CNT: begin
                     if (!ctrl[i][CTRL_EN]) begin
                        state[i] <= S_IDLE;
                     end else if (count[i] > CW'(1)) begin
                        count[i] <= count[i] - CW'(1);
                     end else begin
                        count[i] <= '0;
                        pend[i]  <= 1'b1;
                        state[i] <= S_INT;
                     end
                  end
                  S_INT: begin
                     // Only MODE=01 reloads; the reserved 1x encodings behave as one-shot.
                     if (ctrl[i][2:1] == 2'b01) begin
                        state[i] <= S_LOAD;
                     end else begin
                        ctrl[i][CTRL_EN] <= 1'b0;
                        state[i]         <= S_IDLE;
                     end
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      // NOTE: default assigned first so no mux path leaves Dout unassigned (no latch).
      Dout = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel_ch == 2'(i)) begin
            case (sel_reg)
               R_CTRL:   Dout = {28'h0, ctrl[i]};
               R_PRESET: Dout = 32'(preset[i]);
               R_COUNT:  Dout = 32'(count[i]);
               R_STATUS: Dout = {30'h0, (state[i] == S_CNT), pend[i]};
            endcase
         end
      end
   end

   always_comb begin
      irq_vec = '0;
      for (int i = 0; i < NCH; i++) irq_vec[i] = pend[i] & ctrl[i][CTRL_IM];
   end

   assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: closed-form timelines plus a phase-index reference model
// driven by randomized register traffic; a second instance covers CW=8 and NCH=4.
module tb_multi_timer;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:2] addr  = '0;
   logic        we_a  = 1'b0;
   logic        we_b  = 1'b0;
   logic [31:0] din   = '0;
   logic [31:0] dout_a, dout_b;
   logic        irq_a, irq_b;
   logic [1:0]  vec_a;
   logic [3:0]  vec_b;

   int vectors     = 0;
   int miscompares = 0;

   always #10 clk = ~clk;

   multi_timer #(.NCH(2), .CW(32)) dut_a (
      .clk(clk), .reset(reset), .Addr(addr), .WE(we_a), .Din(din),
      .Dout(dout_a), .IRQ(irq_a), .irq_vec(vec_a)
   );

   multi_timer #(.NCH(4), .CW(8)) dut_b (
      .clk(clk), .reset(reset), .Addr(addr), .WE(we_b), .Din(din),
      .Dout(dout_b), .IRQ(irq_b), .irq_vec(vec_b)
   );

   // Reference model of dut_a: ph = -1 idle, 0 loading, 1..len counting, len+1 terminal.
   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] preset;
      logic [31:0] count;
      logic [31:0] pa;
      logic        pend;
      int          ph;
   } chan_t;

   chan_t m [2];

   function automatic int cnt_len(logic [31:0] p);
      return (p == 0) ? 1 : int'(p);
   endfunction

   function automatic logic [31:0] exp_reg(int ch, int r);
      logic run;
      if (ch > 1) return 32'h0;
      run = (m[ch].ph >= 1) && (m[ch].ph <= cnt_len(m[ch].pa));
      case (r)
         0:       return {28'h0, m[ch].ctrl};
         1:       return m[ch].preset;
         2:       return m[ch].count;
         default: return {30'h0, run, m[ch].pend};
      endcase
   endfunction

   function automatic logic [2:0] exp_irq();
      logic [1:0] v;
      v = {m[1].pend & m[1].ctrl[3], m[0].pend & m[0].ctrl[3]};
      return {|v, v};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m[i].ctrl   = '0;
         m[i].preset = '0;
         m[i].count  = '0;
         m[i].pa     = '0;
         m[i].pend   = 1'b0;
         m[i].ph     = -1;
      end
   endtask

   task automatic model_edge(input bit wr, input int ch, input int r, input logic [31:0] d);
      for (int i = 0; i < 2; i++) begin
         if (wr && ch == i) begin
            case (r)
               0:       m[i].ctrl = d[3:0];
               1:       m[i].preset = d;
               3:       if (d[0]) m[i].pend = 1'b0;
               default: ;
            endcase
         end else if (m[i].ph < 0) begin
            if (m[i].ctrl[0]) m[i].ph = 0;
         end else if (m[i].ph == 0) begin
            m[i].pa    = m[i].preset;
            m[i].count = m[i].pa;
            m[i].ph    = 1;
         end else if (m[i].ph <= cnt_len(m[i].pa)) begin
            if (!m[i].ctrl[0]) begin
               m[i].ph = -1;
            end else if (m[i].ph == cnt_len(m[i].pa)) begin
               m[i].count = '0;
               m[i].pend  = 1'b1;
               m[i].ph    = cnt_len(m[i].pa) + 1;
            end else begin
               m[i].count = m[i].pa - 32'(m[i].ph);
               m[i].ph++;
            end
         end else if (m[i].ctrl[2:1] == 2'b01) begin
            m[i].ph = 0;
         end else begin
            m[i].ctrl[0] = 1'b0;
            m[i].ph      = -1;
         end
      end
   endtask

   // One bus cycle on dut_a; the upper address bits are random since the bridge decodes them.
   task automatic bus(input bit wr, input int ch, input int r, input logic [31:0] d);
      addr = {26'($urandom), 2'(ch), 2'(r)};
      din  = d;
      we_a = wr;
      @(posedge clk);
      model_edge(wr, ch, r, d);
      #1;
      we_a = 1'b0;
   endtask

   task automatic bus_b(input bit wr, input int ch, input int r, input logic [31:0] d);
      addr = {26'($urandom), 2'(ch), 2'(r)};
      din  = d;
      we_b = wr;
      @(posedge clk);
      #1;
      we_b = 1'b0;
   endtask

   task automatic rd_a(input int ch, input int r, output logic [31:0] d);
      addr = {26'($urandom), 2'(ch), 2'(r)};
      #1;
      d = dout_a;
   endtask

   task automatic rd_b(input int ch, input int r, output logic [31:0] d);
      addr = {26'($urandom), 2'(ch), 2'(r)};
      #1;
      d = dout_b;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      we_a  = 1'b1;
      we_b  = 1'b1;
      addr  = 30'($urandom);
      din   = $urandom;
      @(posedge clk);
      #1;
      reset = 1'b0;
      we_a  = 1'b0;
      we_b  = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      logic [31:0] got;
      do_reset();
      bus(1, 0, 1, 32'd3);
      bus(1, 0, 0, 32'h9);
      repeat (3) bus(0, 0, 0, 32'h0);
      do_reset();
      for (int a = 0; a < 16; a++) begin
         rd_a(a / 4, a % 4, got);
         vectors++;
         if (got !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read addr %0d: got %h want 0", a, got);
         end
      end
      vectors++;
      if ({irq_a, vec_a, irq_b, vec_b} !== 8'h0) begin
         miscompares++;
         $display("FAIL reset_irq: got a=%b/%b b=%b/%b want all 0", irq_a, vec_a, irq_b, vec_b);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] got, exp_cnt;
      int p;
      do_reset();
      p = $urandom_range(2, 10);
      bus(1, 0, 1, 32'(p));
      bus(1, 0, 0, 32'h9);
      for (int c = 1; c <= p + 6; c++) begin
         exp_cnt = (c >= 3 && c <= p + 2) ? 32'(p - (c - 3)) : 32'h0;
         rd_a(0, 2, got);
         vectors++;
         if (got !== exp_cnt) begin
            miscompares++;
            $display("FAIL oneshot_count c%0d p%0d: got %0d want %0d", c, p, got, exp_cnt);
         end
         rd_a(0, 3, got);
         vectors++;
         if (got !== {30'h0, (c >= 3 && c <= p + 2), (c >= p + 3)}) begin
            miscompares++;
            $display("FAIL oneshot_status c%0d p%0d: got %h", c, p, got);
         end
         vectors++;
         if ({irq_a, vec_a} !== {(c >= p + 3), 1'b0, (c >= p + 3)}) begin
            miscompares++;
            $display("FAIL oneshot_irq c%0d p%0d: got %b/%b", c, p, irq_a, vec_a);
         end
         bus(0, 0, 0, 32'h0);
      end
      rd_a(0, 0, got);
      vectors++;
      if (got !== 32'h8) begin
         miscompares++;
         $display("FAIL oneshot_ctrl: got %h want 8", got);
      end
      bus(1, 0, 3, 32'h1);
      rd_a(0, 3, got);
      vectors++;
      if (got !== 32'h0 || irq_a !== 1'b0) begin
         miscompares++;
         $display("FAIL oneshot_w1c: got status %h irq %b want 0/0", got, irq_a);
      end
   endtask

   task automatic test_periodic();
      logic [31:0] got, stop_cnt;
      logic [2:0]  ei;
      bit          stopped;
      int          p;
      do_reset();
      p = $urandom_range(2, 6);
      bus(1, 1, 1, 32'(p));
      bus(1, 1, 0, 32'hB);
      for (int c = 0; c < 30; c++) begin
         rd_a(1, 2, got);
         vectors++;
         if (got !== exp_reg(1, 2)) begin
            miscompares++;
            $display("FAIL periodic_count c%0d: got %0d want %0d", c, got, exp_reg(1, 2));
         end
         rd_a(1, 3, got);
         vectors++;
         if (got !== exp_reg(1, 3)) begin
            miscompares++;
            $display("FAIL periodic_status c%0d: got %h want %h", c, got, exp_reg(1, 3));
         end
         ei = exp_irq();
         vectors++;
         if ({irq_a, vec_a} !== ei) begin
            miscompares++;
            $display("FAIL periodic_irq c%0d: got %b%b want %b", c, irq_a, vec_a, ei);
         end
         if (m[1].pend && $urandom_range(0, 1) == 1) bus(1, 1, 3, 32'h1);
         else bus(0, 0, 0, 32'h0);
      end
      stopped  = 1'b0;
      stop_cnt = '0;
      for (int c = 0; c < 20 && !stopped; c++) begin
         if (m[1].ph >= 1 && m[1].ph <= cnt_len(m[1].pa) && m[1].count >= 2) begin
            stop_cnt = m[1].count;
            bus(1, 1, 0, 32'h0);
            stopped = 1'b1;
         end else begin
            bus(0, 0, 0, 32'h0);
         end
      end
      if (!stopped) begin
         miscompares++;
         $display("FAIL periodic_stop: no counting window within 20 cycles");
      end
      repeat (3) bus(0, 0, 0, 32'h0);
      rd_a(1, 3, got);
      vectors++;
      if (got[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL periodic_run_after_stop: got RUN %b want 0", got[1]);
      end
      rd_a(1, 2, got);
      vectors++;
      if (got !== stop_cnt) begin
         miscompares++;
         $display("FAIL periodic_hold: got %0d want %0d", got, stop_cnt);
      end
   endtask

   task automatic test_mask();
      logic [31:0] got;
      int p;
      do_reset();
      p = $urandom_range(1, 5);
      bus(1, 0, 1, 32'(p));
      bus(1, 0, 0, 32'h1);
      repeat (p + 4) bus(0, 0, 0, 32'h0);
      rd_a(0, 3, got);
      vectors++;
      if (got !== 32'h1 || irq_a !== 1'b0 || vec_a !== 2'b00) begin
         miscompares++;
         $display("FAIL mask_off: got status %h irq %b vec %b want 1/0/00", got, irq_a, vec_a);
      end
      bus(1, 0, 0, 32'h8);
      vectors++;
      if (irq_a !== 1'b1 || vec_a !== 2'b01) begin
         miscompares++;
         $display("FAIL mask_on: got irq %b vec %b want 1/01", irq_a, vec_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      do_reset();
      bus(1, 0, 1, 32'($urandom_range(20, 30)));
      bus(1, 0, 0, 32'h3);
      bus(1, 1, 1, 32'd3);
      bus(1, 1, 0, 32'hB);
      for (int c = 0; c < 40; c++) begin
         for (int ch = 0; ch < 2; ch++) begin
            for (int r = 2; r < 4; r++) begin
               rd_a(ch, r, got);
               vectors++;
               if (got !== exp_reg(ch, r)) begin
                  miscompares++;
                  $display("FAIL b2b c%0d ch%0d r%0d: got %h want %h", c, ch, r, got, exp_reg(ch, r));
               end
            end
         end
         if ($urandom_range(0, 1) == 1) bus(1, 1, 1, 32'($urandom_range(1, 6)));
         else bus(0, 0, 0, 32'h0);
      end
   endtask

   task automatic test_random();
      logic [31:0] got, d;
      logic [2:0]  ei;
      int          ch, r;
      do_reset();
      for (int c = 0; c < 150; c++) begin
         for (int k = 0; k < 8; k++) begin
            rd_a(k / 4, k % 4, got);
            vectors++;
            if (got !== exp_reg(k / 4, k % 4)) begin
               miscompares++;
               $display("FAIL random c%0d ch%0d r%0d: got %h want %h", c, k / 4, k % 4, got, exp_reg(k / 4, k % 4));
            end
         end
         rd_a($urandom_range(2, 3), $urandom_range(0, 3), got);
         vectors++;
         if (got !== 32'h0) begin
            miscompares++;
            $display("FAIL random_absent c%0d: got %h want 0", c, got);
         end
         ei = exp_irq();
         vectors++;
         if ({irq_a, vec_a} !== ei) begin
            miscompares++;
            $display("FAIL random_irq c%0d: got %b%b want %b", c, irq_a, vec_a, ei);
         end
         ch = $urandom_range(0, 3);
         r  = $urandom_range(0, 3);
         d  = (r == 1) ? 32'($urandom_range(0, 6)) : $urandom;
         bus($urandom_range(0, 2) == 0, ch, r, d);
      end
   endtask

   task automatic test_cw8();
      logic [31:0] got;
      do_reset();
      bus_b(1, 3, 1, 32'h1FF);
      rd_b(3, 1, got);
      vectors++;
      if (got !== 32'hFF) begin
         miscompares++;
         $display("FAIL cw8_preset: got %h want ff", got);
      end
      bus_b(1, 3, 2, 32'h55);
      rd_b(3, 2, got);
      vectors++;
      if (got !== 32'h0) begin
         miscompares++;
         $display("FAIL cw8_count_ro: got %h want 0", got);
      end
      bus_b(1, 3, 1, 32'h0);
      bus_b(1, 3, 0, 32'h9);
      for (int c = 1; c <= 5; c++) begin
         rd_b(3, 3, got);
         vectors++;
         if (got !== {30'h0, (c == 3), (c >= 4)}) begin
            miscompares++;
            $display("FAIL cw8_status c%0d: got %h", c, got);
         end
         vectors++;
         if ({irq_b, vec_b} !== {(c >= 4), (c >= 4), 3'b000}) begin
            miscompares++;
            $display("FAIL cw8_irq c%0d: got %b/%b", c, irq_b, vec_b);
         end
         bus_b(0, 0, 0, 32'h0);
      end
      rd_b(3, 0, got);
      vectors++;
      if (got !== 32'h8) begin
         miscompares++;
         $display("FAIL cw8_ctrl: got %h want 8", got);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_mask();
      test_back_to_back();
      test_random();
      test_cw8();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
